// File: rtl/fn_cache_if.sv
// rtl/fn_cache_if.sv - client and memory handshake bundle for fn_cache
//
// Purpose: groups the client request/response channel and the memory
// address/data/receive channel used by fn_cache.
// Modports:
//   slave  - the cache side: responder to the client, initiator to memory.
//   master - the environment side: client plus memory.
// Signals:
//   REQ_ADDR_VALID/REQ_ADDR/REQ_DATA_VALID/REQ_DATA/REQ_READY  client request
//   RESP_VALID/RESP_DATA/RESP_READY                            client read response
//   MEM_ADDR_VALID/MEM_ADDR/MEM_DATA_VALID/MEM_DATA/MEM_READY  memory request
//   MEM_RECV_VALID/MEM_RECV_DATA/MEM_RECV_READY                memory read data
interface fn_cache_if;
    logic        REQ_ADDR_VALID;
    logic [31:0] REQ_ADDR;
    logic        REQ_DATA_VALID;
    logic [31:0] REQ_DATA;
    logic        REQ_READY;
    logic        RESP_VALID;
    logic [31:0] RESP_DATA;
    logic        RESP_READY;
    logic        MEM_ADDR_VALID;
    logic [31:0] MEM_ADDR;
    logic        MEM_DATA_VALID;
    logic [31:0] MEM_DATA;
    logic        MEM_READY;
    logic        MEM_RECV_VALID;
    logic [31:0] MEM_RECV_DATA;
    logic        MEM_RECV_READY;

    modport slave (
        input  REQ_ADDR_VALID, REQ_ADDR, REQ_DATA_VALID, REQ_DATA, RESP_READY,
               MEM_READY, MEM_RECV_VALID, MEM_RECV_DATA,
        output REQ_READY, RESP_VALID, RESP_DATA, MEM_ADDR_VALID, MEM_ADDR,
               MEM_DATA_VALID, MEM_DATA, MEM_RECV_READY
    );

    modport master (
        output REQ_ADDR_VALID, REQ_ADDR, REQ_DATA_VALID, REQ_DATA, RESP_READY,
               MEM_READY, MEM_RECV_VALID, MEM_RECV_DATA,
        input  REQ_READY, RESP_VALID, RESP_DATA, MEM_ADDR_VALID, MEM_ADDR,
               MEM_DATA_VALID, MEM_DATA, MEM_RECV_READY
    );
endinterface

// File: rtl/fn_cache.sv
// rtl/fn_cache.sv - direct-mapped word cache between function_expander and memory
//
// Purpose: serves repeated function-descriptor reads from local storage.
// Read misses are filled from memory; writes go through to memory and only
// update a line that already holds the same tag. One transaction at a time.
// Ports:
//   CLK    clock
//   RST    synchronous active-high reset; returns to idle, invalidates all lines
//   FLUSH  pulse; invalidates all lines at the next idle edge
//   bus    fn_cache_if.slave: client request/response and memory channels
module fn_cache #(
    parameter int IDX_BITS = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       FLUSH,
    fn_cache_if.slave  bus
);
    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam int LINES    = 1 << IDX_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_SEND,
        S_MISS_RECV,
        S_RESP,
        S_WRITE
    } state_t;

    state_t              state_q, state_d;
    logic                flush_pend_q, flush_pend_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [LINES-1:0]    valid_q, valid_d;

    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic                mem_addr_valid_q, mem_addr_valid_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic                mem_data_valid_q, mem_data_valid_d;
    logic [31:0]         mem_data_q, mem_data_d;
    logic                mem_recv_ready_q, mem_recv_ready_d;

    // Line tags and words carry no reset; the valid bits alone gate hits.
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         word_mem [LINES];

    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic                hit;
    logic                flush_do;
    logic                word_we;
    logic                tag_we;
    logic [31:0]         word_wdata;

    assign idx = addr_q[IDX_BITS+1:2];
    assign tag = addr_q[31:IDX_BITS+2];
    assign hit = valid_q[idx] && (tag_mem[idx] == tag);

    // A pending flush is serviced only from idle, so a fill in progress
    // always completes before its line can be invalidated.
    assign flush_do = (state_q == S_IDLE) && flush_pend_q;

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q || FLUSH;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        valid_d      = valid_q;
        resp_data_d  = resp_data_q;
        word_we      = 1'b0;
        tag_we       = 1'b0;
        word_wdata   = 32'h0;

        if (flush_do) begin
            valid_d      = '0;
            flush_pend_d = FLUSH;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.REQ_ADDR_VALID && req_ready_q) begin
                    // Masking reads every address bit while keeping the
                    // latched byte offset at zero for the memory address.
                    addr_d  = bus.REQ_ADDR & 32'hFFFF_FFFC;
                    wdata_d = bus.REQ_DATA;
                    state_d = bus.REQ_DATA_VALID ? S_WRITE : S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    resp_data_d = word_mem[idx];
                    state_d     = S_RESP;
                end else begin
                    state_d = S_MISS_SEND;
                end
            end
            S_MISS_SEND: begin
                if (bus.MEM_READY && mem_addr_valid_q) begin
                    state_d = S_MISS_RECV;
                end
            end
            S_MISS_RECV: begin
                if (bus.MEM_RECV_VALID && mem_recv_ready_q) begin
                    word_we      = 1'b1;
                    tag_we       = 1'b1;
                    word_wdata   = bus.MEM_RECV_DATA;
                    valid_d[idx] = 1'b1;
                    resp_data_d  = bus.MEM_RECV_DATA;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.RESP_READY && resp_valid_q) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (bus.MEM_READY && mem_addr_valid_q) begin
                    // Write-through, no-allocate: only a matching line is updated.
                    if (hit) begin
                        word_we    = 1'b1;
                        word_wdata = wdata_q;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so every valid is held
        // with stable data until its transfer. REQ_READY is withheld for the
        // idle cycle in which a pending flush is applied.
        req_ready_d      = (state_d == S_IDLE) && !flush_pend_d;
        resp_valid_d     = (state_d == S_RESP);
        mem_recv_ready_d = (state_d == S_MISS_RECV);
        mem_addr_valid_d = (state_d == S_MISS_SEND) || (state_d == S_WRITE);
        mem_data_valid_d = (state_d == S_WRITE);
        mem_addr_d       = mem_addr_valid_d ? addr_d : 32'h0;
        mem_data_d       = mem_data_valid_d ? wdata_d : 32'h0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q          <= S_IDLE;
            flush_pend_q     <= 1'b0;
            addr_q           <= 32'h0;
            wdata_q          <= 32'h0;
            valid_q          <= '0;
            req_ready_q      <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_data_q      <= 32'h0;
            mem_addr_valid_q <= 1'b0;
            mem_addr_q       <= 32'h0;
            mem_data_valid_q <= 1'b0;
            mem_data_q       <= 32'h0;
            mem_recv_ready_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            flush_pend_q     <= flush_pend_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            valid_q          <= valid_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_data_q      <= resp_data_d;
            mem_addr_valid_q <= mem_addr_valid_d;
            mem_addr_q       <= mem_addr_d;
            mem_data_valid_q <= mem_data_valid_d;
            mem_data_q       <= mem_data_d;
            mem_recv_ready_q <= mem_recv_ready_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (word_we) begin
                word_mem[idx] <= word_wdata;
            end
            if (tag_we) begin
                tag_mem[idx] <= tag;
            end
        end
    end

    assign bus.REQ_READY      = req_ready_q;
    assign bus.RESP_VALID     = resp_valid_q;
    assign bus.RESP_DATA      = resp_data_q;
    assign bus.MEM_ADDR_VALID = mem_addr_valid_q;
    assign bus.MEM_ADDR       = mem_addr_q;
    assign bus.MEM_DATA_VALID = mem_data_valid_q;
    assign bus.MEM_DATA       = mem_data_q;
    assign bus.MEM_RECV_READY = mem_recv_ready_q;
endmodule
